pe_conv_controller: RTL

PE_CONV_CONTROLLER -- requirements
Module: pe_conv_controller

---
 rtl/pe_conv_controller.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pe_conv_controller.sv
// pe_conv_controller: sequences K-tap convolution reads into an external PE and returns one result per output.
// Optional build macro PE_CTRL_RELU_EN clamps negative captured results to zero.
module pe_conv_controller #(
  parameter int I_X    = 8,
  parameter int I_W    = 8,
  parameter int O_PSUM = 19,
  parameter int K      = 9,
  parameter int N_OUT  = 8,
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_x_addr,
  output logic [ADDR_W-1:0] o_w_addr,
  input  logic [I_X-1:0]    i_x_data,
  input  logic [I_W-1:0]    i_w_data,
  output logic [I_X-1:0]    o_pe_x,
  output logic [I_W-1:0]    o_pe_w,
  output logic [O_PSUM-1:0] o_pe_psum,
  input  logic [O_PSUM-1:0] i_pe_psum,
  output logic [O_PSUM-1:0] o_result,
  output logic              o_valid,
  input  logic              i_ready
);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, OUT, DONE} state_t;

  localparam logic [ADDR_W-1:0] LastTap = ADDR_W'(K - 1);
  localparam logic [ADDR_W-1:0] LastOut = ADDR_W'(N_OUT - 1);
  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

  state_t              state_q;
  logic [ADDR_W-1:0]   tap_q;
  logic [ADDR_W-1:0]   out_idx_q;
  logic [ADDR_W-1:0]   x_addr_q;
  logic [ADDR_W-1:0]   w_addr_q;
  logic                drain_q;
  logic                first_q;
  logic                rd_en_q;
  logic                busy_q;
  logic                done_q;
  logic                valid_q;
  logic [O_PSUM-1:0]   result_q;
  logic [O_PSUM-1:0]   capture_d;

  always_comb begin
`ifdef PE_CTRL_RELU_EN
    capture_d = i_pe_psum[O_PSUM-1] ? '0 : i_pe_psum;
`else
    capture_d = i_pe_psum;
`endif
  end

  // first_q marks the cycle in which tap-0 read data arrives, one cycle after its read strobe
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      tap_q     <= '0;
      out_idx_q <= '0;
      x_addr_q  <= '0;
      w_addr_q  <= '0;
      drain_q   <= 1'b0;
      first_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      first_q <= (state_q == FETCH) && (tap_q == '0);
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            state_q   <= FETCH;
            tap_q     <= '0;
            out_idx_q <= '0;
            x_addr_q  <= '0;
            w_addr_q  <= '0;
            rd_en_q   <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        FETCH: begin
          if (tap_q == LastTap) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
            drain_q <= 1'b0;
          end else begin
            tap_q    <= tap_q + AddrOne;
            x_addr_q <= out_idx_q + tap_q + AddrOne;
            w_addr_q <= tap_q + AddrOne;
          end
        end
        // Two drain cycles cover the read latency plus the PE register
        DRAIN: begin
          if (drain_q) begin
            result_q <= capture_d;
            valid_q  <= 1'b1;
            state_q  <= OUT;
          end else begin
            drain_q <= 1'b1;
          end
        end
        OUT: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            if (out_idx_q < LastOut) begin
              out_idx_q <= out_idx_q + AddrOne;
              tap_q     <= '0;
              x_addr_q  <= out_idx_q + AddrOne;
              w_addr_q  <= '0;
              rd_en_q   <= 1'b1;
              state_q   <= FETCH;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_rd_en   = rd_en_q;
  assign o_x_addr  = x_addr_q;
  assign o_w_addr  = w_addr_q;
  assign o_pe_x    = i_x_data;
  assign o_pe_w    = i_w_data;
  assign o_pe_psum = first_q ? '0 : i_pe_psum;
  assign o_result  = result_q;
  assign o_valid   = valid_q;

endmodule
